fir_output_decimator: RTL and testbench

- Downstream stage of the pipelined FIR filter. Consumes the 16-bit unsigned filter output, one word per clock.
- Discards the pipeline warm-up samples after reset, then boxcar-averages each group of 2^DEC_LOG2 samples.
- Rounds, rescales and saturates each group result to OUT_W bits.
- Buffers results in a small show-ahead FIFO drained by a valid/ready consumer.

---
 rtl/fir_output_decimator.sv | 158 +++++++++++++++
 tb/tb_fir_output_decimator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_decimator.sv
`default_nettype none
// ============================================================================
// fir_output_decimator : drops FIR warm-up samples, boxcar-averages groups of
// 2^DEC_LOG2 words, rounds/saturates to OUT_W bits, queues in a show-ahead FIFO
// Revision 1.0
// ============================================================================
module fir_output_decimator #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int DEC_LOG2   = 2,
  parameter int SHIFT      = 4,
  parameter int WARMUP     = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [IN_W-1:0]               sample_in,
  input  logic                          sample_en,
  input  logic                          clear_flags,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          warm,
  output logic                          overflow,
  output logic                          sat
);

  localparam int c_D     = 1 << DEC_LOG2;
  localparam int c_ACC_W = IN_W + DEC_LOG2;
  localparam int c_SC_W  = c_ACC_W + 1;
  localparam int c_T     = DEC_LOG2 + SHIFT;
  localparam int c_PH_W  = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam int c_WU_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [c_WU_W-1:0]  r_wu_cnt;
  logic               r_warm;
  logic [c_PH_W-1:0]  r_phase;
  logic [c_ACC_W-1:0] r_acc;
  logic [OUT_W-1:0]   r_result;
  logic               r_push;
  logic [OUT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;
  logic               r_sat;

  logic               w_accept;
  logic               w_done;
  logic [c_ACC_W-1:0] w_sum;
  logic [c_SC_W-1:0]  w_scaled;
  logic               w_sat;
  logic [OUT_W-1:0]   w_result;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;

  // The sample that completes warm-up is itself discarded: accumulation keys off the old r_warm.
  assign w_accept = sample_en & r_warm;
  assign w_done   = w_accept & (r_phase == c_PH_W'(c_D - 1));
  assign w_sum    = r_acc + c_ACC_W'(sample_in);

  generate
    if (c_T > 0) begin : g_round
      localparam logic [c_SC_W-1:0] c_HALF = c_SC_W'(1) << (c_T - 1);
      logic [c_SC_W-1:0] w_rounded;
      assign w_rounded = {1'b0, w_sum} + c_HALF;
      assign w_scaled  = w_rounded >> c_T;
    end else begin : g_no_round
      assign w_scaled = {1'b0, w_sum};
    end

    if (c_SC_W > OUT_W) begin : g_clip
      assign w_sat    = |w_scaled[c_SC_W-1:OUT_W];
      assign w_result = w_sat ? '1 : w_scaled[OUT_W-1:0];
    end else begin : g_fit
      assign w_sat    = 1'b0;
      assign w_result = OUT_W'(w_scaled);
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wu_cnt <= '0;
      r_warm   <= 1'b0;
    end else if (sample_en && !r_warm) begin
      if (r_wu_cnt == c_WU_W'(WARMUP - 1)) r_warm <= 1'b1;
      else                                  r_wu_cnt <= r_wu_cnt + c_WU_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_phase  <= '0;
      r_result <= '0;
      r_push   <= 1'b0;
    end else begin
      r_push <= w_done;
      if (w_done) begin
        r_acc    <= '0;
        r_phase  <= '0;
        r_result <= w_result;
      end else if (w_accept) begin
        r_acc    <= w_sum;
        r_phase  <= r_phase + c_PH_W'(1);
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_pop   = ~w_empty & out_ready;
  // A pop frees the slot this same edge, so a full FIFO can still take the push.
  assign w_wr    = r_push & (~w_full | w_pop);
  assign w_drop  = r_push & w_full & ~w_pop;

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_result;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_wr && !w_pop)      r_count <= r_count + c_CNT_W'(1);
      else if (!w_wr && w_pop) r_count <= r_count - c_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_overflow <= (r_overflow & ~clear_flags) | w_drop;
      r_sat      <= (r_sat & ~clear_flags) | (w_done & w_sat);
    end
  end

  assign out_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_valid  = ~w_empty;
  assign fifo_count = r_count;
  assign warm       = r_warm;
  assign overflow   = r_overflow;
  assign sat        = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_fir_output_decimator.sv
`default_nettype none
// ============================================================================
// tb_fir_output_decimator : directed + random stimulus against a queue-based
// reference model of the decimator. Revision 1.0
// ============================================================================
module tb_fir_output_decimator;

  localparam int IN_W       = 16;
  localparam int OUT_W      = 8;
  localparam int DEC_LOG2   = 2;
  localparam int SHIFT      = 4;
  localparam int WARMUP     = 11;
  localparam int FIFO_DEPTH = 4;
  localparam int D          = 1 << DEC_LOG2;
  localparam int T          = DEC_LOG2 + SHIFT;
  localparam int MAXV       = (1 << OUT_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [IN_W-1:0]   sample_in;
  logic              sample_en;
  logic              clear_flags;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        fifo_count;
  logic              warm;
  logic              overflow;
  logic              sat;

  always #5 clock = ~clock;

  fir_output_decimator #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEC_LOG2(DEC_LOG2), .SHIFT(SHIFT),
    .WARMUP(WARMUP), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .sample_in(sample_in), .sample_en(sample_en),
    .clear_flags(clear_flags), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .warm(warm),
    .overflow(overflow), .sat(sat)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counts, a running group sum and a queue standing in for the FIFO.
  int m_wcnt;
  bit m_warm;
  int m_sum;
  int m_n;
  bit m_pend;
  int m_pval;
  int m_fifo[$];
  bit m_ovf;
  bit m_sat;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_warm = 0; m_sum = 0; m_n = 0;
    m_pend = 0; m_pval = 0; m_ovf = 0; m_sat = 0;
    m_fifo.delete();
  endtask

  task automatic check_outputs();
    check_eq("out_valid",  32'(out_valid),  32'(m_fifo.size() > 0));
    check_eq("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
    check_eq("out_data",   32'(out_data),   (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'd0);
    check_eq("warm",       32'(warm),       32'(m_warm));
    check_eq("overflow",   32'(overflow),   32'(m_ovf));
    check_eq("sat",        32'(sat),        32'(m_sat));
  endtask

  task automatic model_step(input bit se, input int d, input bit rdy, input bit clr);
    bit pop;
    bit ovf_set = 0;
    bit sat_set = 0;
    bit npend = 0;
    int nval = 0;
    int sc;
    int dummy;
    pop = (m_fifo.size() > 0) && rdy;
    if (se) begin
      if (!m_warm) begin
        m_wcnt++;
        if (m_wcnt == WARMUP) m_warm = 1;
      end else begin
        m_sum += d;
        m_n++;
        if (m_n == D) begin
          sc = (T > 0) ? ((m_sum + (1 << (T - 1))) >> T) : m_sum;
          if (sc > MAXV) begin sc = MAXV; sat_set = 1; end
          npend = 1; nval = sc; m_sum = 0; m_n = 0;
        end
      end
    end
    if (pop) dummy = m_fifo.pop_front();
    if (m_pend) begin
      if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(m_pval);
      else ovf_set = 1;
    end
    m_ovf  = (m_ovf && !clr) || ovf_set;
    m_sat  = (m_sat && !clr) || sat_set;
    m_pend = npend;
    m_pval = nval;
  endtask

  // One clock: drive, check current state at negedge, advance model, settle after posedge.
  task automatic cyc(input bit se, input logic [15:0] d, input bit rdy, input bit clr);
    sample_en = se; sample_in = d; out_ready = rdy; clear_flags = clr;
    @(negedge clock);
    check_outputs();
    model_step(se, int'(d), rdy, clr);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cyc(1'b0, 16'h0, rdy, 1'b0);
  endtask

  task automatic grp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                     input logic [15:0] e, input bit rdy, input bit clr_last, input int gap);
    cyc(1'b1, a, rdy, 1'b0); idle(gap, rdy);
    cyc(1'b1, b, rdy, 1'b0); idle(gap, rdy);
    cyc(1'b1, c, rdy, 1'b0); idle(gap, rdy);
    cyc(1'b1, e, rdy, clr_last);
  endtask

  // Reset raised between edges; outputs must clear before the next clock edge.
  task automatic async_reset();
    sample_en = 1'b0; sample_in = '0; out_ready = 1'b0; clear_flags = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] d;
    reset = 1'b1; sample_en = 1'b0; sample_in = '0; out_ready = 1'b0; clear_flags = 1'b0;
    model_reset();
    #12;
    check_outputs();
    reset = 1'b0;
    @(posedge clock); #1;

    // Warm-up discard then first group of 0x0100
    repeat (WARMUP - 1) cyc(1'b1, 16'hFFFF, 1'b1, 1'b0);
    check_eq("tp1_warm_before", 32'(warm), 32'd0);
    cyc(1'b1, 16'hFFFF, 1'b1, 1'b0);
    check_eq("tp1_warm_after", 32'(warm), 32'd1);
    grp(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b0, 0);
    check_eq("tp1_valid_early", 32'(out_valid), 32'd0);
    idle(1, 1'b1);
    check_eq("tp1_valid", 32'(out_valid), 32'd1);
    check_eq("tp1_data",  32'(out_data),  32'h10);
    check_eq("tp1_sat",   32'(sat),       32'd0);
    idle(2, 1'b1);

    // Rounding at and just below the half point
    grp(16'h0010, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
    idle(1, 1'b0);
    check_eq("tp2_half_up", 32'(out_data), 32'h01);
    idle(1, 1'b1);
    grp(16'h000F, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
    idle(1, 1'b0);
    check_eq("tp2_below_half_valid", 32'(out_valid), 32'd1);
    check_eq("tp2_below_half", 32'(out_data), 32'h00);
    idle(2, 1'b1);

    // Saturation and sticky-flag clearing
    grp(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
    idle(1, 1'b1);
    check_eq("tp3_sat_data", 32'(out_data), 32'hFF);
    check_eq("tp3_sat_set", 32'(sat), 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    check_eq("tp3_sat_clr", 32'(sat), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    grp(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 0);
    check_eq("tp3_set_wins", 32'(sat), 32'd1);
    idle(2, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);

    // Backpressure: fifth result dropped, then drain in order
    repeat (5) grp(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 1);
    idle(2, 1'b0);
    check_eq("tp4_count_full", 32'(fifo_count), 32'd4);
    check_eq("tp4_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq("tp4_drain_data", 32'(out_data), 32'h10);
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
    end
    check_eq("tp4_empty_valid", 32'(out_valid), 32'd0);
    check_eq("tp4_empty_count", 32'(fifo_count), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);

    // Push and pop together while full
    repeat (4) grp(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 0);
    idle(2, 1'b0);
    grp(16'h0200, 16'h0200, 16'h0200, 16'h0200, 1'b0, 1'b0, 0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check_eq("tp5_count", 32'(fifo_count), 32'd4);
    check_eq("tp5_no_ovf", 32'(overflow), 32'd0);
    idle(3, 1'b1);
    check_eq("tp5_last_word", 32'(out_data), 32'h20);
    idle(2, 1'b1);

    // Asynchronous reset mid-group with two entries queued
    grp(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 0);
    grp(16'h0300, 16'h0300, 16'h0300, 16'h0300, 1'b0, 1'b0, 0);
    idle(2, 1'b0);
    check_eq("tp6_count_two", 32'(fifo_count), 32'd2);
    cyc(1'b1, 16'h0100, 1'b0, 1'b0);
    cyc(1'b1, 16'h0100, 1'b0, 1'b0);
    async_reset();
    repeat (WARMUP) cyc(1'b1, 16'h0400, 1'b0, 1'b0);
    check_eq("tp6_no_out_warmup", 32'(out_valid), 32'd0);
    grp(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 0);
    idle(1, 1'b0);
    check_eq("tp6_first_after", 32'(out_data), 32'h10);
    idle(2, 1'b1);

    // Random traffic with occasional async reset
    for (int i = 0; i < 3000; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h1100));
      if ($urandom_range(0, 599) == 0) async_reset();
      else cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) == 0,
               $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
